// File: rtl/gabor_window_5x5.sv
// gabor_window_5x5: streaming 5x5 window generator feeding the 45-degree Gabor
// convolution stage. Pixels arrive in raster order. Four line memories hold
// the previous lines. A 5x5 shift register presents the neighbourhood
// row-major: pixel1 is the oldest row and column, pixel25 is the newest pixel.
// Optional feature: define GABOR_WIN_SOF_EN to add the in_sof port. An accept
// with in_sof=1 forces the pixel to position (0,0) for resynchronisation.
module gabor_window_5x5 #(
  parameter int pixel_int_width = 9,
  parameter int pixel_dec_width = 0,
  parameter int img_width       = 516,
  parameter int img_height      = 516,
  parameter int kernel_size     = 5,
  localparam int P              = pixel_int_width + pixel_dec_width
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
`ifdef GABOR_WIN_SOF_EN
  input  logic                in_sof,
`endif
  output logic                in_ready,
  input  logic signed [P-1:0] in_pixel,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [P-1:0] pixel1,  pixel2,  pixel3,  pixel4,  pixel5,
  output logic signed [P-1:0] pixel6,  pixel7,  pixel8,  pixel9,  pixel10,
  output logic signed [P-1:0] pixel11, pixel12, pixel13, pixel14, pixel15,
  output logic signed [P-1:0] pixel16, pixel17, pixel18, pixel19, pixel20,
  output logic signed [P-1:0] pixel21, pixel22, pixel23, pixel24, pixel25,
  output logic                frame_done
);

  localparam int CW = $clog2(img_width);
  localparam int RW = $clog2(img_height);
  localparam logic [CW-1:0] COL_LAST  = CW'(img_width - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(img_height - 1);
  localparam logic [CW-1:0] COL_WIN0  = CW'(4);
  localparam logic [RW-1:0] ROW_WIN0  = RW'(4);

  // The pre-adder layout downstream only exists for a 5x5 kernel.
  if (kernel_size != 5) begin : g_bad_kernel
    $error("gabor_window_5x5: kernel_size must be 5");
  end

  logic [CW-1:0] col, eff_col;
  logic [RW-1:0] row, eff_row;
  logic          sof, accept, stream, emit, last;

  logic [P-1:0]  line_mem [0:3][0:img_width-1];
  logic [P-1:0]  tap      [0:3];
  logic [4:0][P-1:0]      ncol;
  logic [4:0][4:0][P-1:0] win;   // win[row][col], row 0 = oldest line

`ifdef GABOR_WIN_SOF_EN
  assign sof = in_sof;
`else
  assign sof = 1'b0;
`endif

  // A start-of-frame accept behaves as if the counters already read (0,0).
  assign eff_col  = sof ? '0 : col;
  assign eff_row  = sof ? '0 : row;
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  // Rows 0..3 are FILL; from row 4 on the window is vertically complete.
  assign stream   = (eff_row >= ROW_WIN0);
  // Columns 0..3 would straddle the previous line, so they emit nothing.
  assign emit     = stream && (eff_col >= COL_WIN0);
  assign last     = (eff_row == ROW_LAST) && (eff_col == COL_LAST);

  // Column taps from the four previous lines at the current column.
  always_comb begin
    for (int k = 0; k < 4; k++) tap[k] = line_mem[k][eff_col];
  end

  assign ncol[0] = tap[3];
  assign ncol[1] = tap[2];
  assign ncol[2] = tap[1];
  assign ncol[3] = tap[0];
  assign ncol[4] = in_pixel;

  // Line memories: push the new pixel in and age each line by one slot.
  always_ff @(posedge clk) begin
    if (accept) begin
      line_mem[0][eff_col] <= in_pixel;
      for (int k = 1; k < 4; k++) line_mem[k][eff_col] <= line_mem[k-1][eff_col];
    end
  end

  // Raster position counters; they wrap at end of line and end of frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (eff_col == COL_LAST) begin
        col <= '0;
        row <= (eff_row == ROW_LAST) ? '0 : eff_row + 1'b1;
      end else begin
        col <= eff_col + 1'b1;
        row <= eff_row;
      end
    end
  end

  // Window shift register: shift left one column and load the new right column.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win <= '0;
    end else if (accept) begin
      for (int i = 0; i < 5; i++) begin
        for (int j = 0; j < 4; j++) win[i][j] <= win[i][j+1];
        win[i][4] <= ncol[i];
      end
    end
  end

  // Output handshake. frame_done is a single pulse on the first cycle of the last window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= accept && emit && last;
      if (accept)         out_valid <= emit;
      else if (out_ready) out_valid <= 1'b0;
    end
  end

  assign pixel1  = win[0][0]; assign pixel2  = win[0][1]; assign pixel3  = win[0][2];
  assign pixel4  = win[0][3]; assign pixel5  = win[0][4];
  assign pixel6  = win[1][0]; assign pixel7  = win[1][1]; assign pixel8  = win[1][2];
  assign pixel9  = win[1][3]; assign pixel10 = win[1][4];
  assign pixel11 = win[2][0]; assign pixel12 = win[2][1]; assign pixel13 = win[2][2];
  assign pixel14 = win[2][3]; assign pixel15 = win[2][4];
  assign pixel16 = win[3][0]; assign pixel17 = win[3][1]; assign pixel18 = win[3][2];
  assign pixel19 = win[3][3]; assign pixel20 = win[3][4];
  assign pixel21 = win[4][0]; assign pixel22 = win[4][1]; assign pixel23 = win[4][2];
  assign pixel24 = win[4][3]; assign pixel25 = win[4][4];

endmodule

// File: tb/tb_gabor_window_5x5.sv
// Bench for gabor_window_5x5 on a small 8x6 frame. A raster-image model
// produces the expected windows. They are queued when the window-producing
// pixel is accepted and compared when the DUT hands the window downstream.
module tb_gabor_window_5x5;
  localparam int P  = 9;
  localparam int W  = 8;
  localparam int H  = 6;
  localparam int WV = 25 * P;
  localparam int NEVER = 1 << 30;

  logic clk = 1'b0, rst = 1'b0;
  logic in_valid = 1'b0, out_ready = 1'b0, in_sof = 1'b0;
  logic in_ready, out_valid, frame_done;
  logic signed [P-1:0] in_pixel = '0;
  logic signed [P-1:0] px [25];

  gabor_window_5x5 #(.pixel_int_width(9), .pixel_dec_width(0), .img_width(W),
                     .img_height(H), .kernel_size(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
`ifdef GABOR_WIN_SOF_EN
    .in_sof(in_sof),
`endif
    .in_ready(in_ready), .in_pixel(in_pixel), .out_valid(out_valid), .out_ready(out_ready),
    .pixel1(px[0]),   .pixel2(px[1]),   .pixel3(px[2]),   .pixel4(px[3]),   .pixel5(px[4]),
    .pixel6(px[5]),   .pixel7(px[6]),   .pixel8(px[7]),   .pixel9(px[8]),   .pixel10(px[9]),
    .pixel11(px[10]), .pixel12(px[11]), .pixel13(px[12]), .pixel14(px[13]), .pixel15(px[14]),
    .pixel16(px[15]), .pixel17(px[16]), .pixel18(px[17]), .pixel19(px[18]), .pixel20(px[19]),
    .pixel21(px[20]), .pixel22(px[21]), .pixel23(px[22]), .pixel24(px[23]), .pixel25(px[24]),
    .frame_done(frame_done));

  always #5 clk = ~clk;

  logic [WV-1:0] exp_q[$];
  bit            last_q[$];
  int n_chk = 0, n_fail = 0, n_win = 0, n_fd = 0;
  int mr = 0, mc = 0;
  logic signed [P-1:0] img [H][W];

  task automatic check(input logic [WV-1:0] obs, input logic [WV-1:0] exp, input string tag);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WV-1:0] dut_win();
    logic [WV-1:0] v;
    for (int i = 0; i < 25; i++) v[i*P +: P] = px[i];
    return v;
  endfunction

  function automatic logic signed [P-1:0] gen(input int mode);
    case (mode)
      0:       return P'(8 * mr + mc);
      1:       return P'(-256 + mc);
      default: return P'($urandom_range(511));
    endcase
  endfunction

  // Reference: record the pixel in the raster image and queue any window it completes.
  task automatic model_accept(input logic signed [P-1:0] pix, input bit sof);
    logic [WV-1:0] w;
    if (sof) begin mr = 0; mc = 0; end
    img[mr][mc] = pix;
    if (mr >= 4 && mc >= 4) begin
      for (int i = 0; i < 5; i++)
        for (int j = 0; j < 5; j++) w[(i*5+j)*P +: P] = img[mr-4+i][mc-4+j];
      exp_q.push_back(w);
      last_q.push_back(mr == H-1 && mc == W-1);
    end
    if (mc == W-1) begin mc = 0; mr = (mr == H-1) ? 0 : mr + 1; end
    else mc++;
  endtask

  // One clock cycle: drive on the falling edge, then check what the next rising edge will do.
  task automatic cyc(input bit iv, input logic signed [P-1:0] pix, input bit ordy,
                     input bit sof, output bit acc);
    @(negedge clk);
    in_valid = iv; in_pixel = pix; out_ready = ordy; in_sof = sof;
    #1;
    if (frame_done) begin
      n_fd++;
      check(WV'(out_valid && last_q.size() > 0 && last_q[0]), WV'(1), "frame_done_align");
    end
    if (out_valid && !out_ready) begin
      check(WV'(in_ready), WV'(0), "stall_in_ready");
      if (exp_q.size() > 0) check(dut_win(), exp_q[0], "stall_hold");
    end
    acc = in_valid && in_ready;
    if (out_valid && out_ready) begin
      check(WV'(exp_q.size() != 0), WV'(1), "window_expected");
      if (exp_q.size() != 0) begin
        check(dut_win(), exp_q.pop_front(), "window");
        void'(last_q.pop_front());
        n_win++;
      end
    end
    if (acc) model_accept(pix, sof);
  endtask

  task automatic feed(input int mode, input int npix, input int vpct, input int rpct,
                      input int stall_at, input int stop_k);
    int k = 0, n = 0;
    bit acc, iv, ordy;
    logic signed [P-1:0] pix;
    pix = gen(mode);
    while (k < npix && n < 20 * npix + 100) begin
      if (k == stop_k) return;
      iv   = ($urandom_range(99) < vpct);
      ordy = ($urandom_range(99) < rpct);
      if (n >= stall_at && n < stall_at + 10) ordy = 1'b0;
      cyc(iv, pix, ordy, 1'b0, acc);
      n++;
      if (acc) begin k++; pix = gen(mode); end
    end
    check(WV'(k), WV'(npix), "feed_progress");
  endtask

  task automatic drain();
    int n = 0;
    bit acc;
    while (exp_q.size() > 0 && n < 50) begin cyc(1'b0, '0, 1'b1, 1'b0, acc); n++; end
    check(WV'(exp_q.size()), WV'(0), "drain_empty");
    cyc(1'b0, '0, 1'b1, 1'b0, acc);
    check(WV'(out_valid), WV'(0), "valid_falls");
  endtask

  initial begin
    int w0, f0;
    bit acc;
    logic [P-1:0] e;
    // Reset state
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check(WV'(out_valid), WV'(0), "rst_out_valid");
    check(WV'(in_ready), WV'(1), "rst_in_ready");
    check(WV'(frame_done), WV'(0), "rst_frame_done");
    check(dut_win(), '0, "rst_window");
    @(negedge clk); rst = 1'b0;

    // Ramp frame 8*r+c, with a directed look at the first window
    w0 = n_win; f0 = n_fd;
    feed(0, 37, 100, 100, NEVER, -1);
    @(posedge clk); #1;
    check(WV'(out_valid), WV'(1), "ramp_first_valid");
    check(WV'($unsigned(px[0])), WV'(0), "ramp_pixel1");
    check(WV'($unsigned(px[12])), WV'(18), "ramp_pixel13");
    check(WV'($unsigned(px[24])), WV'(36), "ramp_pixel25");
    feed(0, 11, 100, 100, NEVER, -1);
    drain();
    check(WV'(n_win - w0), WV'(8), "ramp_windows");
    check(WV'(n_fd - f0), WV'(1), "ramp_frame_done");

    // Negative pixels -256+c
    w0 = n_win;
    feed(1, 37, 100, 100, NEVER, -1);
    @(posedge clk); #1;
    e = P'(-252);
    check(WV'($unsigned(px[24])), WV'(e), "neg_pixel25");
    feed(1, 11, 100, 100, NEVER, -1);
    drain();
    check(WV'(n_win - w0), WV'(8), "neg_windows");

    // Backpressure: out_ready low for 10 cycles in STREAM
    w0 = n_win; f0 = n_fd;
    feed(0, 48, 100, 100, 40, -1);
    drain();
    check(WV'(n_win - w0), WV'(8), "bp_windows");
    check(WV'(n_fd - f0), WV'(1), "bp_frame_done");

    // Random handshakes over three back-to-back frames
    w0 = n_win; f0 = n_fd;
    feed(2, 3 * W * H, 50, 50, NEVER, -1);
    drain();
    check(WV'(n_win - w0), WV'(24), "rand_windows");
    check(WV'(n_fd - f0), WV'(3), "rand_frame_done");

    // Asynchronous reset at pixel (5,3), then a full clean frame
    feed(0, 48, 100, 100, NEVER, 5 * W + 3);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0;
    #1;
    check(WV'(out_valid), WV'(0), "midrst_out_valid");
    check(WV'(frame_done), WV'(0), "midrst_frame_done");
    check(WV'(in_ready), WV'(1), "midrst_in_ready");
    check(dut_win(), '0, "midrst_window");
    exp_q.delete(); last_q.delete(); mr = 0; mc = 0;
    @(negedge clk); rst = 1'b0;
    w0 = n_win; f0 = n_fd;
    feed(2, 48, 100, 100, NEVER, -1);
    drain();
    check(WV'(n_win - w0), WV'(8), "postrst_windows");
    check(WV'(n_fd - f0), WV'(1), "postrst_frame_done");

`ifdef GABOR_WIN_SOF_EN
    // Start-of-frame resync at (2,5)
    feed(0, 48, 100, 100, NEVER, 2 * W + 5);
    w0 = n_win; f0 = n_fd;
    acc = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) cyc(1'b1, P'(100), 1'b1, 1'b1, acc);
    check(WV'(acc), WV'(1), "sof_accept");
    feed(0, 47, 100, 100, NEVER, -1);
    drain();
    check(WV'(n_win - w0), WV'(8), "sof_windows");
    check(WV'(n_fd - f0), WV'(1), "sof_frame_done");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
